flash_cache: RTL
================

Name: flash_cache

Overview:
- Small direct-mapped, read-only line cache between the CPU instruction/data bus and the QSPI flash read controller (`spimemio`).
- Misses refill a whole line with line-aligned sequential word reads. This keeps the flash controller in its continuous-read mode: consecutive addresses never trigger a jump or re-issue.
- Hits are served without touching the flash.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; power of two, ≥2.
- ADDR_W, 24, byte address width on both sides.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- cpu_valid  in  1  request; held high until cpu_ready.
- cpu_ready  out  1  one-cycle response strobe.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- flush  in  1  invalidate all lines (single-cycle pulse or level).
- mem_valid  out  1  read request to flash controller.
- mem_ready  in  1  flash controller accept + data strobe (may be combinational from mem_valid/mem_addr).
- mem_addr  out  ADDR_W  word-aligned flash byte address.
- mem_rdata  in  32  flash read data, sampled when mem_valid && mem_ready.

Behaviour:
- Address split:
  - off = addr[OFF_W+1:2], OFF_W = clog2(WORDS).
  - idx = next IDX_W bits, IDX_W = clog2(LINES).
  - tag = remaining upper bits. With defaults: off [3:2], idx [7:4], tag [23:8].
- Storage: per line a valid bit and a tag (flops), plus a data RAM of LINES*WORDS x32 with synchronous read and one write port.
- Output registering: all outputs are registered; no combinational path from mem_ready to mem_valid or mem_addr.
- Reset values: state=IDLE; all valid bits 0; cpu_ready=0; mem_valid=0; mem_addr=0; cpu_rdata=0.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - On cpu_valid, latch cpu_addr into req_addr, issue RAM read at {idx,off}, go to LOOKUP.
- LOOKUP:
  - hit = valid[idx] && tag_q[idx]==tag.
  - Hit: cpu_rdata <= RAM output; go to RESP.
  - Miss: mem_valid <= 1; mem_addr <= {tag,idx,0,2'b00}; word counter wc <= 0; clear valid[idx]; go to FILL.
- FILL:
  - On each mem_valid && mem_ready: write mem_rdata to RAM[{idx,wc}]; if wc==off, cpu_rdata <= mem_rdata; wc++; mem_addr += 4.
  - mem_valid stays high continuously between words. No deassert gap is required or allowed.
  - When wc==WORDS-1 is accepted: mem_valid <= 0; tag_q[idx] <= tag; valid[idx] <= !flush_pend; go to RESP.
  - mem_ready stalls of any length: mem_valid and mem_addr are held stable.
- RESP:
  - cpu_ready=1 for exactly one cycle, then IDLE. IDLE cannot accept a new request in the RESP cycle.
- Latency: cpu_valid first high in cycle N (state IDLE):
  - Hit: cpu_ready in cycle N+2.
  - Miss: first mem_valid in cycle N+2; cpu_ready one cycle after the final word handshake.
- flush:
  - In IDLE, LOOKUP or RESP: all valid bits cleared on the next edge. A lookup in that same cycle still uses the pre-flush valid bits.
  - In FILL: valid bits cleared; flush_pend set, so the completing line stays invalid. The CPU still receives correct data.
  - flush_pend is cleared on entering IDLE.
- cpu_valid dropping mid-transaction is a protocol violation. The fill still completes and RESP still pulses.
- Reset mid-fill: mem_valid=0 on the next edge; no RAM write on the reset cycle; all lines invalid.
- Arithmetic:
  - wc is OFF_W bits and wraps only at line end.
  - mem_addr increments modulo 2^ADDR_W; a line never crosses a line boundary by construction.

Decomposition:
- flash_cache_pkg: ADDR_W default, OFF_W/IDX_W/TAG_W derivation functions, state enum {IDLE, LOOKUP, FILL, RESP}.
- One sub-module, flash_cache_ram: LINES*WORDS x32 synchronous-read, single-write RAM, so it can map to EBR.
- Tags and valid bits stay as flops in flash_cache.

Test Plan:
- Cold miss at 0x000104: mem_addr sequence is 0x000100, 0x000104, 0x000108, 0x00010C with mem_valid never dropping between them; cpu_rdata = flash word 0x000104; cpu_ready exactly once.
- Hit after fill: read 0x000108 → cpu_ready 2 cycles after cpu_valid, mem_valid stays 0, data = flash word 0x000108.
- Conflict: 0x000104 then 0x001104 (same idx 0, tag 0x0011) → refill 0x001100..0x00110C; then 0x000104 misses again.
- mem_ready stall: hold mem_ready=0 for 20 cycles on word 2 → mem_valid=1 and mem_addr=0x000108 stable throughout; correct data afterwards.
- flush during FILL of 0x000200 → CPU gets correct word; immediate re-read of 0x000200 misses and refetches.
- resetn=0 for one cycle mid-fill → mem_valid=0 next cycle; previously cached 0x000104 misses afterwards.

Source files
------------

// File: rtl/flash_cache_pkg.sv
// flash_cache_pkg
//   Shared definitions for the flash line cache: default address width,
//   address-field width helpers and the controller state encoding.
package flash_cache_pkg;

   localparam int FC_ADDR_W = 24;

   // word-offset bits inside a line
   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   // line-index bits
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // tag bits = what is left above index, offset and the byte lanes
   function automatic int tag_w(input int addr_w, input int lines, input int words);
      return addr_w - $clog2(lines) - $clog2(words) - 2;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL,
      RESP
   } state_e;

endpackage

// File: rtl/flash_cache_ram.sv
// flash_cache_ram
//   Line data store: DEPTH x 32, one write port, one synchronous read port,
//   so it can map onto block RAM.
// Ports:
//   clk      clock
//   we_i     write enable          waddr_i / wdata_i  write address / data
//   re_i     read enable           raddr_i            read address
//   rdata_o  read data, valid the cycle after re_i
module flash_cache_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/flash_cache.sv
// flash_cache
//   Direct-mapped read-only line cache in front of the QSPI flash reader.
//   Misses refill the whole line with line-aligned sequential word reads so
//   the flash stays in continuous-read mode; hits never touch the flash.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cpu_valid/cpu_ready  CPU request / one-cycle response strobe
//   cpu_addr/cpu_rdata   CPU byte address / read data
//   flush                invalidate all lines
//   mem_valid/mem_ready  flash read request / accept+data strobe
//   mem_addr/mem_rdata   flash word address / read data
module flash_cache
   import flash_cache_pkg::*;
#(
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int ADDR_W = FC_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [31:0]       cpu_rdata,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata
);

   localparam int OFF_W  = off_w(WORDS);
   localparam int IDX_W  = idx_w(LINES);
   localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS);
   localparam int RAM_AW = IDX_W + OFF_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:2]   req_q, req_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q [LINES];
   logic [OFF_W-1:0]    wc_q, wc_d;
   logic                mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                cpu_ready_q, cpu_ready_d;
   logic [31:0]         cpu_rdata_q, cpu_rdata_d;
   logic                fpend_q, fpend_d;

   logic                tag_we, ram_re, ram_we, hit, hs;
   logic [31:0]         ram_rdata;
   logic                unused_lsb;

   // byte lanes are irrelevant for a word cache
   assign unused_lsb = ^cpu_addr[1:0];

   // fields of the latched request
   logic [OFF_W-1:0] r_off;
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   assign r_off = req_q[OFF_W+1:2];
   assign r_idx = req_q[OFF_W+2 +: IDX_W];
   assign r_tag = req_q[ADDR_W-1 -: TAG_W];

   // lookup compares against registered valid bits, so a flush arriving in
   // the LOOKUP cycle does not affect that lookup
   assign hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign hs  = mem_valid_q && mem_ready;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      valid_d     = valid_q;
      wc_d        = wc_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      cpu_rdata_d = cpu_rdata_q;
      fpend_d     = fpend_q;
      tag_we      = 1'b0;
      ram_re      = 1'b0;
      ram_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_valid) begin
               req_d   = cpu_addr[ADDR_W-1:2];
               ram_re  = 1'b1;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cpu_rdata_d = ram_rdata;
               state_d     = RESP;
            end else begin
               mem_valid_d      = 1'b1;
               mem_addr_d       = {r_tag, r_idx, {OFF_W{1'b0}}, 2'b00};
               wc_d             = '0;
               valid_d[r_idx]   = 1'b0;
               state_d          = FILL;
            end
         end
         FILL: begin
            if (hs) begin
               ram_we = resetn;
               if (wc_q == r_off) cpu_rdata_d = mem_rdata;
               wc_d       = wc_q + 1'b1;
               mem_addr_d = mem_addr_q + ADDR_W'(4);
               if (wc_q == OFF_W'(WORDS - 1)) begin
                  mem_valid_d    = 1'b0;
                  tag_we         = 1'b1;
                  valid_d[r_idx] = !fpend_q;
                  state_d        = RESP;
               end
            end
         end
         RESP: begin
            fpend_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // flush wins over any valid-bit update of this cycle; during a fill it
      // also keeps the line being written from becoming valid
      if (flush) begin
         valid_d = '0;
         if (state_q == FILL) fpend_d = 1'b1;
      end
   end

   assign cpu_ready_d = (state_d == RESP);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         req_q       <= '0;
         valid_q     <= '0;
         wc_q        <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         cpu_ready_q <= 1'b0;
         cpu_rdata_q <= '0;
         fpend_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         valid_q     <= valid_d;
         wc_q        <= wc_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         fpend_q     <= fpend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      end else if (tag_we) begin
         tag_q[r_idx] <= r_tag;
      end
   end

   flash_cache_ram #(
      .DEPTH (LINES * WORDS),
      .AW    (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i ({r_idx, wc_q}),
      .wdata_i (mem_rdata),
      .re_i    (ram_re),
      .raddr_i ({cpu_addr[OFF_W+2 +: IDX_W], cpu_addr[OFF_W+1:2]}),
      .rdata_o (ram_rdata)
   );

   assign cpu_ready = cpu_ready_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;

endmodule
